// File: rtl/genesis_pad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : genesis_pad_scanner
//  Description : Polls NUM_PADS Genesis-style controllers that share a single
//                select line. Runs the 8-phase select sequence, detects
//                3-button vs 6-button pads, debounces across frames and
//                publishes active-high button vectors with press pulses.
//  Ports       : clock, reset      - system clock, synchronous active-high reset
//                controller_pins   - raw active-low pad data, 6 bits per pad
//                controller_select - shared select line (idles high)
//                buttons           - debounced buttons, 12 bits per pad
//                                    {Mode,Z,Y,X,Start,C,B,A,Right,Left,Down,Up}
//                pressed           - one-cycle 0->1 pulses of buttons
//                six_button        - debounced 6-button detection per pad
//                frame_done        - one-cycle pulse when a poll is committed
//  Revision    : 1.0 - initial release
// ============================================================================
module genesis_pad_scanner #(
    parameter int NUM_PADS      = 1,
    parameter int PHASE_CYCLES  = 16,
    parameter int IDLE_CYCLES   = 2048,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6*NUM_PADS-1:0]   controller_pins,
    output logic                    controller_select,
    output logic [12*NUM_PADS-1:0]  buttons,
    output logic [12*NUM_PADS-1:0]  pressed,
    output logic [NUM_PADS-1:0]     six_button,
    output logic                    frame_done
);

    localparam int c_CNT_MAX = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam int c_STB_W   = $clog2(STABLE_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POLL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]           r_phase, w_phase_nxt;
    logic                 w_select;
    logic                 w_phase_end;   // last cycle of a poll phase: sample point
    logic                 w_commit;      // last cycle of phase 7: commit on this edge

    logic [6*NUM_PADS-1:0] r_sync1, r_sync2;
    logic [6*NUM_PADS-1:0] w_pins;       // synchronised, active-high

    // ------------------------------------------------------------------------
    // Input synchroniser; resets to the released (high) pin level
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= controller_pins;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pins = ~r_sync2;

    // ------------------------------------------------------------------------
    // Poll sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_phase_nxt = r_phase;
        w_select    = 1'b1;
        w_phase_end = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cnt == c_CNT_W'(IDLE_CYCLES - 1)) begin
                    w_state_nxt = S_POLL;
                    w_cnt_nxt   = '0;
                    w_phase_nxt = '0;
                end
            end
            S_POLL: begin
                // Even phases drive select low, odd phases high
                w_select = r_phase[0];
                if (r_cnt == c_CNT_W'(PHASE_CYCLES - 1)) begin
                    w_phase_end = 1'b1;
                    w_cnt_nxt   = '0;
                    if (r_phase == 3'd7) begin
                        w_state_nxt = S_COMMIT;
                        w_commit    = 1'b1;
                    end else begin
                        w_phase_nxt = r_phase + 3'd1;
                    end
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign controller_select = w_select;
    assign frame_done        = (r_state == S_COMMIT);

    // ------------------------------------------------------------------------
    // Per-pad raw capture and cross-frame debounce
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [5:0]          w_d;
        logic [11:0]         r_raw_btn;
        logic                r_raw_det;
        logic [12:0]         w_raw;
        logic [12:0]         r_prev;
        logic [c_STB_W-1:0]  r_stb, w_stb_nxt;
        logic                w_same, w_load;
        logic [11:0]         r_btn, r_prs;
        logic                r_six;

        assign w_d   = w_pins[6*p +: 6];
        assign w_raw = {r_raw_det, r_raw_btn};

        always_ff @(posedge clock) begin
            if (reset) begin
                r_raw_btn <= '0;
                r_raw_det <= 1'b0;
            end else if (w_phase_end) begin
                case (r_phase)
                    3'd0: begin
                        r_raw_btn[4] <= w_d[4];                     // A
                        r_raw_btn[7] <= w_d[5];                     // Start
                    end
                    3'd1: begin
                        r_raw_btn[3:0] <= w_d[3:0];                 // Right,Left,Down,Up
                        r_raw_btn[5]   <= w_d[4];                   // B
                        r_raw_btn[6]   <= w_d[5];                   // C
                    end
                    // A 6-button pad pulls D0..D3 low on its third low phase
                    3'd4: r_raw_det <= &w_d[3:0];
                    3'd5: begin
                        // Extended buttons only exist when the pad identified itself
                        r_raw_btn[10] <= r_raw_det & w_d[0];        // Z
                        r_raw_btn[9]  <= r_raw_det & w_d[1];        // Y
                        r_raw_btn[8]  <= r_raw_det & w_d[2];        // X
                        r_raw_btn[11] <= r_raw_det & w_d[3];        // Mode
                    end
                    default: ;
                endcase
            end
        end

        always_comb begin
            w_same    = (w_raw == r_prev);
            w_stb_nxt = c_STB_W'(1);
            if (w_same) begin
                w_stb_nxt = (r_stb == c_STB_W'(STABLE_FRAMES)) ? r_stb : r_stb + 1'b1;
            end
            w_load = (w_stb_nxt == c_STB_W'(STABLE_FRAMES));
        end

        // Updated on the edge into COMMIT so frame_done, pressed and the new
        // button state all become visible together during the COMMIT cycle.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_prev <= '0;
                r_stb  <= '0;
                r_btn  <= '0;
                r_prs  <= '0;
                r_six  <= 1'b0;
            end else begin
                r_prs <= '0;
                if (w_commit) begin
                    r_stb <= w_stb_nxt;
                    if (!w_same) begin
                        r_prev <= w_raw;
                    end
                    if (w_load) begin
                        r_btn <= w_raw[11:0];
                        r_six <= w_raw[12];
                        r_prs <= w_raw[11:0] & ~r_btn;
                    end
                end
            end
        end

        assign buttons[12*p +: 12] = r_btn;
        assign pressed[12*p +: 12] = r_prs;
        assign six_button[p]       = r_six;
    end

endmodule
`default_nettype wire
